// File: rtl/upsample_pkg.sv
// Shared definitions for the stereo upsampling scheduler: channel codes,
// FSM state encoding and default sample width.
package upsample_pkg;

    localparam int DATA_WIDTH_DFLT = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ_L = 2'd1,
        ST_REQ_R = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

endpackage

// File: rtl/upsample_tick_gen.sv
// Output-rate tick generator: free-running 0..TICK_DIV-1 counter that
// pulses on its last count while enabled and is held at zero otherwise.
module upsample_tick_gen #(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gating with the live enable means a tick cannot escape in the cycle enable falls.
    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/upsample_sched.sv
// Time-multiplexes one single-channel interpolator core across the left and
// right halves of a stereo frame, one left/right request pair per output tick.
module upsample_sched
    import upsample_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DFLT,
    parameter int UP_FACTOR    = 8,
    parameter int TICK_DIV     = 16,
    parameter int CORE_TIMEOUT = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*DATA_WIDTH-1:0]       in_frame,
    output logic                          core_req,
    output logic                          core_ch,
    output logic                          core_load,
    output logic [DATA_WIDTH-1:0]         core_din,
    input  logic                          core_ack,
    input  logic [DATA_WIDTH-1:0]         core_dout,
    output logic                          out_valid,
    output logic [2*DATA_WIDTH-1:0]       out_frame,
    output logic [$clog2(UP_FACTOR)-1:0]  phase,
    output logic                          underrun,
    output logic                          late,
    output logic                          timeout
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = $clog2(UP_FACTOR);
    localparam int WW = $clog2(CORE_TIMEOUT + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(UP_FACTOR - 1);
    localparam logic [WW-1:0] WAIT_END = WW'(CORE_TIMEOUT - 1);

    logic            tick;
    state_e          state_q;
    logic [PW-1:0]   phase_q;
    logic [2*DW-1:0] frame_q;
    logic [DW-1:0]   l_res_q;
    logic [2*DW-1:0] out_frame_q;
    logic [WW-1:0]   wait_q;
    logic            underrun_q;
    logic            late_q;
    logic            timeout_q;

    logic            is_idle;
    logic            fetch_d;
    logic            step_done_d;
    logic [DW-1:0]   res_d;
    logic [PW-1:0]   phase_inc_d;

    upsample_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    assign is_idle     = (state_q == ST_IDLE);
    assign fetch_d     = is_idle && tick && (phase_q == '0);
    assign step_done_d = core_ack || (wait_q == WAIT_END);
    // A timed-out channel contributes a zero sample rather than stale data.
    assign res_d       = core_ack ? core_dout : '0;
    assign phase_inc_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            frame_q     <= '0;
            l_res_q     <= '0;
            out_frame_q <= '0;
            wait_q      <= '0;
            underrun_q  <= 1'b0;
            late_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (tick && !is_idle) begin
                late_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        if (phase_q == '0) begin
                            if (in_valid) begin
                                frame_q <= in_frame;
                            end else begin
                                underrun_q <= 1'b1;
                            end
                        end
                        wait_q  <= '0;
                        state_q <= ST_REQ_L;
                    end else if (!enable) begin
                        phase_q <= '0;
                    end
                end
                ST_REQ_L: begin
                    if (step_done_d) begin
                        l_res_q <= res_d;
                        wait_q  <= '0;
                        state_q <= ST_REQ_R;
                        if (!core_ack) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                ST_REQ_R: begin
                    if (step_done_d) begin
                        out_frame_q <= {l_res_q, res_d};
                        state_q     <= ST_EMIT;
                        if (!core_ack) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                ST_EMIT: begin
                    phase_q <= phase_inc_d;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign in_ready  = fetch_d;
    assign core_req  = (state_q == ST_REQ_L) || (state_q == ST_REQ_R);
    assign core_ch   = (state_q == ST_REQ_R) ? CH_RIGHT : CH_LEFT;
    assign core_load = core_req && (phase_q == '0);
    assign core_din  = (state_q == ST_REQ_L) ? frame_q[2*DW-1:DW] :
                       (state_q == ST_REQ_R) ? frame_q[DW-1:0]    : '0;
    assign out_valid = (state_q == ST_EMIT);
    assign out_frame = out_frame_q;
    assign phase     = phase_q;
    assign underrun  = underrun_q;
    assign late      = late_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_upsample_sched.sv
// Directed bench for upsample_sched with a behavioural core responder and a
// queue scoreboard of expected output frames and phases.
module tb_upsample_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Main instance (TICK_DIV = 16)
    logic        rst_m_n, en_m, iv_m, rdy_m, req_m, ch_m, ld_m, ack_m, ov_m;
    logic        un_m, late_m, to_m;
    logic [31:0] if_m, of_m;
    logic [15:0] din_m, dout_m;
    logic [2:0]  ph_m;
    int          ackd_m = 1;
    int          acnt_m = 0;
    logic        nack_r_m = 1'b0;

    // Fast instance (TICK_DIV = 4)
    logic        rst_f_n, en_f, iv_f, rdy_f, req_f, ch_f, ld_f, ack_f, ov_f;
    logic        un_f, late_f, to_f;
    logic [31:0] if_f, of_f;
    logic [15:0] din_f, dout_f;
    logic [2:0]  ph_f;
    int          ackd_f = 3;
    int          acnt_f = 0;

    upsample_sched #(.DATA_WIDTH(16), .UP_FACTOR(8), .TICK_DIV(16), .CORE_TIMEOUT(6)) u_dut (
        .clk(clk), .reset_n(rst_m_n), .enable(en_m), .in_valid(iv_m), .in_ready(rdy_m),
        .in_frame(if_m), .core_req(req_m), .core_ch(ch_m), .core_load(ld_m),
        .core_din(din_m), .core_ack(ack_m), .core_dout(dout_m), .out_valid(ov_m),
        .out_frame(of_m), .phase(ph_m), .underrun(un_m), .late(late_m), .timeout(to_m)
    );

    upsample_sched #(.DATA_WIDTH(16), .UP_FACTOR(8), .TICK_DIV(4), .CORE_TIMEOUT(6)) u_fast (
        .clk(clk), .reset_n(rst_f_n), .enable(en_f), .in_valid(iv_f), .in_ready(rdy_f),
        .in_frame(if_f), .core_req(req_f), .core_ch(ch_f), .core_load(ld_f),
        .core_din(din_f), .core_ack(ack_f), .core_dout(dout_f), .out_valid(ov_f),
        .out_frame(of_f), .phase(ph_f), .underrun(un_f), .late(late_f), .timeout(to_f)
    );

    // Core models: ack after a programmable number of request cycles, result = din + 1.
    assign ack_m  = req_m && (acnt_m >= ackd_m) && !(nack_r_m && ch_m);
    assign dout_m = din_m + 16'd1;
    assign ack_f  = req_f && (acnt_f >= ackd_f);
    assign dout_f = din_f + 16'd1;

    always @(posedge clk) begin
        acnt_m <= (req_m && !ack_m) ? acnt_m + 1 : 0;
        acnt_f <= (req_f && !ack_f) ? acnt_f + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_fr_m[$];
    logic [2:0]  exp_ph_m[$];
    logic [31:0] exp_fr_f[$];
    logic [2:0]  exp_ph_f[$];
    int outs_m = 0, last_m = 0, prev_m = 0, ready_m = 0, load_m = 0;
    int outs_f = 0, last_f = 0, prev_f = 0;

    always @(negedge clk) begin
        if (ov_m) begin
            outs_m++;
            prev_m = last_m;
            last_m = cyc;
            if (exp_fr_m.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_main_extra: observed frame 0x%0h, expected no output", of_m);
            end else begin
                chk("sb_main_frame", of_m, exp_fr_m.pop_front());
                chk("sb_main_phase", 32'(ph_m), 32'(exp_ph_m.pop_front()));
            end
        end
        if (rdy_m) ready_m++;
        if (req_m && ld_m) load_m++;
        if (ov_f) begin
            outs_f++;
            prev_f = last_f;
            last_f = cyc;
            if (exp_fr_f.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_fast_extra: observed frame 0x%0h, expected no output", of_f);
            end else begin
                chk("sb_fast_frame", of_f, exp_fr_f.pop_front());
                chk("sb_fast_phase", 32'(ph_f), 32'(exp_ph_f.pop_front()));
            end
        end
    end

    task automatic push_m(input logic [31:0] f, input logic [2:0] p);
        exp_fr_m.push_back(f);
        exp_ph_m.push_back(p);
    endtask

    task automatic push_f(input logic [31:0] f, input logic [2:0] p);
        exp_fr_f.push_back(f);
        exp_ph_f.push_back(p);
    endtask

    task automatic wait_outs(input bit fast, input int n, input int budget, input string tag);
        int target;
        int k;
        target = (fast ? outs_f : outs_m) + n;
        k = 0;
        while (((fast ? outs_f : outs_m) < target) && (k < budget)) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(tag, 32'(fast ? outs_f : outs_m), 32'(target));
    endtask

    task automatic wait_req(input logic ch, input int budget, input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(posedge clk);
            #1;
            if (req_m && (ch_m == ch)) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_cnt;
        rst_m_n = 1'b0; en_m = 1'b1; iv_m = 1'b1; if_m = 32'hFFFF_FFFF;
        rst_f_n = 1'b0; en_f = 1'b0; iv_f = 1'b0; if_f = 32'h0;

        // 1: reset holds everything at zero even with stimulus applied
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(rdy_m), 32'd0);
        chk("rst_core_req", 32'(req_m), 32'd0);
        chk("rst_core_ch", 32'(ch_m), 32'd0);
        chk("rst_core_load", 32'(ld_m), 32'd0);
        chk("rst_core_din", 32'(din_m), 32'd0);
        chk("rst_out_valid", 32'(ov_m), 32'd0);
        chk("rst_out_frame", of_m, 32'd0);
        chk("rst_phase", 32'(ph_m), 32'd0);
        chk("rst_underrun", 32'(un_m), 32'd0);
        chk("rst_late", 32'(late_m), 32'd0);
        chk("rst_timeout", 32'(to_m), 32'd0);

        // 2: nominal frame, eight interpolated outputs
        if_m = 32'h1234_ABCD;
        for (int p = 0; p < 8; p++) push_m(32'h1235_ABCE, 3'(p));
        rst_m_n = 1'b1;
        wait_outs(1'b0, 8, 8 * 16 + 40, "t2_outputs");
        chk("t2_in_ready_pulses", 32'(ready_m), 32'd1);
        chk("t2_load_cycles", 32'(load_m), 32'd4);

        // 3: underrun reuses the held frame
        iv_m = 1'b0;
        if_m = 32'hDEAD_BEEF;
        push_m(32'h1235_ABCE, 3'd0);
        wait_outs(1'b0, 1, 40, "t3_first_output");
        chk("t3_underrun", 32'(un_m), 32'd1);
        chk("t3_gap", 32'(last_m - prev_m), 32'd16);
        iv_m = 1'b1;
        if_m = 32'h0102_0304;
        for (int p = 1; p < 8; p++) push_m(32'h1235_ABCE, 3'(p));
        wait_outs(1'b0, 7, 7 * 16 + 40, "t3_rest_outputs");
        chk("t3_ready_pulses", 32'(ready_m), 32'd2);

        // 4: right channel never acknowledged
        nack_r_m = 1'b1;
        push_m(32'h0103_0000, 3'd0);
        wait_outs(1'b0, 1, 40, "t4_timeout_output");
        chk("t4_timeout", 32'(to_m), 32'd1);
        nack_r_m = 1'b0;
        push_m(32'h0103_0305, 3'd1);
        wait_outs(1'b0, 1, 40, "t4_recover_output");
        chk("t4_timeout_sticky", 32'(to_m), 32'd1);
        chk("t4_underrun_sticky", 32'(un_m), 32'd1);

        // 6a: enable falls during the left request
        wait_req(1'b0, 40, "t6_reach_req_l");
        en_m = 1'b0;
        push_m(32'h0103_0305, 3'd2);
        wait_outs(1'b0, 1, 40, "t6_frame_completes");
        repeat (3) @(posedge clk);
        #1;
        chk("t6_phase_cleared", 32'(ph_m), 32'd0);
        req_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (req_m) req_cnt++;
        end
        chk("t6_no_req_disabled", 32'(req_cnt), 32'd0);
        chk("t6_late_clear", 32'(late_m), 32'd0);

        // 6b: asynchronous reset during the right request
        en_m = 1'b1;
        wait_req(1'b1, 60, "t6_reach_req_r");
        #2;
        rst_m_n = 1'b0;
        #1;
        chk("t6_async_req_drop", 32'(req_m), 32'd0);
        @(posedge clk);
        #1;
        chk("t6_rst_out_frame", of_m, 32'd0);
        chk("t6_rst_phase", 32'(ph_m), 32'd0);
        chk("t6_rst_underrun", 32'(un_m), 32'd0);
        chk("t6_rst_timeout", 32'(to_m), 32'd0);
        chk("t6_rst_out_valid", 32'(ov_m), 32'd0);
        chk("t6_sb_empty", 32'(exp_fr_m.size()), 32'd0);

        // 5: ticks faster than the request sequence are dropped
        if_f = 32'h5555_AAAA;
        iv_f = 1'b1;
        en_f = 1'b1;
        for (int p = 0; p < 4; p++) push_f(32'h5556_AAAB, 3'(p));
        rst_f_n = 1'b1;
        wait_outs(1'b1, 4, 120, "t5_outputs");
        chk("t5_late", 32'(late_f), 32'd1);
        chk("t5_gap", 32'(last_f - prev_f), 32'd12);
        chk("t5_timeout", 32'(to_f), 32'd0);
        chk("t5_underrun", 32'(un_f), 32'd0);
        en_f = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_sb_empty", 32'(exp_fr_f.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
